// File: rtl/lenet_pkg.sv
// ---------------------------------------------------------------------------
// lenet_pkg
// Shared constants and helpers for the LeNet-5 MNIST convolution path.
//   PIX_W    : pixel width in bits
//   KERNEL_K : convolution window size (5x5)
//   IMG_W/H  : input frame dimensions
//   POS_W    : width of raster coordinates
//   WIN_W    : flattened window width, PIX_W*K*K
// Helpers:
//   pix_lsb  : bit offset of pixel (r,c) inside a flattened window
//   win_pix  : extract pixel (r,c) from a flattened window (MAC array side)
// ---------------------------------------------------------------------------
package lenet_pkg;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned KERNEL_K = 5;
    localparam int unsigned IMG_W    = 32;
    localparam int unsigned IMG_H    = 32;
    localparam int unsigned POS_W    = 5;
    localparam int unsigned WIN_W    = PIX_W * KERNEL_K * KERNEL_K;

    typedef logic [PIX_W-1:0] pix_t;

    // Row-major layout: r=0 is the top row, c=0 the oldest (left) column.
    function automatic int unsigned pix_lsb(input int unsigned r, input int unsigned c);
        return PIX_W * (KERNEL_K * r + c);
    endfunction

    function automatic pix_t win_pix(input logic [WIN_W-1:0] win,
                                     input int unsigned      r,
                                     input int unsigned      c);
        return win[pix_lsb(r, c) +: PIX_W];
    endfunction

endpackage

// File: rtl/raster_pos_cnt.sv
// ---------------------------------------------------------------------------
// raster_pos_cnt
// Tracks the raster position of the pixel beat currently on the inputs, with
// start-of-frame resynchronisation and a sticky framing-error flag.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   valid_in   : a beat is present this cycle
//   sof_in     : (qualified by valid_in) beat carries pixel (0,0)
//   x_pos/y_pos: effective position of the current beat (sof forces 0,0)
//   frame_err  : sticky, set when sof arrives while counters are not at (0,0)
// ---------------------------------------------------------------------------
import lenet_pkg::*;

module raster_pos_cnt #(
    parameter int unsigned W  = IMG_W,
    parameter int unsigned H  = IMG_H,
    parameter int unsigned CW = POS_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    input  logic          sof_in,
    output logic [CW-1:0] x_pos,
    output logic [CW-1:0] y_pos,
    output logic          frame_err
);

    localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LAST_X = CW'(W - 1);
    localparam logic [CW-1:0] LAST_Y = CW'(H - 1);

    logic [CW-1:0] x_cnt_r;
    logic [CW-1:0] y_cnt_r;
    logic [CW-1:0] x_nxt_s;
    logic [CW-1:0] y_nxt_s;
    logic          resync_s;
    logic          err_set_s;
    logic          frame_err_r;

    // Effective position of this beat and the position of the following beat.
    always_comb begin
        resync_s  = valid_in & sof_in;
        x_pos     = ZERO;
        y_pos     = ZERO;
        x_nxt_s   = x_cnt_r;
        y_nxt_s   = y_cnt_r;
        // An sof while the counters are already at (0,0) is a normal frame start.
        err_set_s = resync_s & ((x_cnt_r != ZERO) | (y_cnt_r != ZERO));
        if (resync_s) begin
            x_pos = ZERO;
            y_pos = ZERO;
        end else begin
            x_pos = x_cnt_r;
            y_pos = y_cnt_r;
        end
        if (x_pos == LAST_X) begin
            x_nxt_s = ZERO;
            if (y_pos == LAST_Y) begin
                y_nxt_s = ZERO;
            end else begin
                y_nxt_s = y_pos + ONE;
            end
        end else begin
            x_nxt_s = x_pos + ONE;
            y_nxt_s = y_pos;
        end
    end

    // Position counters advance only on beats; error flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_cnt_r     <= ZERO;
            y_cnt_r     <= ZERO;
            frame_err_r <= 1'b0;
        end else begin
            if (valid_in) begin
                x_cnt_r <= x_nxt_s;
                y_cnt_r <= y_nxt_s;
            end
            frame_err_r <= frame_err_r | err_set_s;
        end
    end

    assign frame_err = frame_err_r;

endmodule

// File: rtl/window_5x5_gen.sv
// ---------------------------------------------------------------------------
// window_5x5_gen
// Builds a 5x5 pixel window from vertically aligned 5-pixel columns produced
// by the line buffer and presents every window that lies fully inside the
// image to the C1 MAC array (28x28 windows for a 32x32 frame).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   valid_in, sof_in    : column beat valid / beat carries pixel (0,0)
//   pix_row0..pix_row4  : column pixels, row0 = top (oldest line)
//   win_out             : pixel (r,c) at [8*(5r+c) +: 8], held between windows
//   win_valid           : win_out carries a complete in-image window (pulse)
//   win_first/win_last  : first / last window of the frame (pulses)
//   win_col/win_row     : top-left coordinate of the presented window
//   frame_err           : sticky misplaced-sof flag
// All outputs are registered; latency is one cycle from beat to window.
// ---------------------------------------------------------------------------
import lenet_pkg::*;

module window_5x5_gen #(
    parameter int unsigned IMG_WIDTH  = IMG_W,
    parameter int unsigned IMG_HEIGHT = IMG_H,
    parameter int unsigned K          = KERNEL_K
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic               sof_in,
    input  logic [PIX_W-1:0]   pix_row0,
    input  logic [PIX_W-1:0]   pix_row1,
    input  logic [PIX_W-1:0]   pix_row2,
    input  logic [PIX_W-1:0]   pix_row3,
    input  logic [PIX_W-1:0]   pix_row4,
    output logic [WIN_W-1:0]   win_out,
    output logic               win_valid,
    output logic               win_first,
    output logic               win_last,
    output logic [POS_W-1:0]   win_col,
    output logic [POS_W-1:0]   win_row,
    output logic               frame_err
);

    localparam logic [POS_W-1:0] K_M1   = POS_W'(K - 1);
    localparam logic [POS_W-1:0] LAST_X = POS_W'(IMG_WIDTH - 1);
    localparam logic [POS_W-1:0] LAST_Y = POS_W'(IMG_HEIGHT - 1);

    logic [POS_W-1:0] x_pos_s;
    logic [POS_W-1:0] y_pos_s;
    logic             frame_err_s;

    pix_t             col_in_s  [K];
    pix_t             win_r     [K][K];
    pix_t             win_nxt_s [K][K];
    logic [WIN_W-1:0] win_flat_s;
    logic             emit_s;
    logic             first_s;
    logic             last_s;

    logic [WIN_W-1:0] win_out_r;
    logic             win_valid_r;
    logic             win_first_r;
    logic             win_last_r;
    logic [POS_W-1:0] win_col_r;
    logic [POS_W-1:0] win_row_r;

    raster_pos_cnt #(
        .W  (IMG_WIDTH),
        .H  (IMG_HEIGHT),
        .CW (POS_W)
    ) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .sof_in    (sof_in),
        .x_pos     (x_pos_s),
        .y_pos     (y_pos_s),
        .frame_err (frame_err_s)
    );

    // Gather the incoming column; row0 is the top of the window.
    always_comb begin
        col_in_s[0] = pix_row0;
        col_in_s[1] = pix_row1;
        col_in_s[2] = pix_row2;
        col_in_s[3] = pix_row3;
        col_in_s[4] = pix_row4;
    end

    // Window after this beat's shift, and its flattened form for the output.
    always_comb begin
        win_flat_s = {WIN_W{1'b0}};
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (c < K - 1) begin
                    win_nxt_s[r][c] = win_r[r][c+1];
                end else begin
                    win_nxt_s[r][c] = col_in_s[r];
                end
                win_flat_s[pix_lsb(r, c) +: PIX_W] = win_nxt_s[r][c];
            end
        end
    end

    // A window is complete once the beat is at least K-1 into the row and line.
    // Columns 0..K-2 still hold the previous line's tail below that point.
    always_comb begin
        emit_s  = valid_in & (x_pos_s >= K_M1) & (y_pos_s >= K_M1);
        first_s = emit_s & (x_pos_s == K_M1) & (y_pos_s == K_M1);
        last_s  = emit_s & (x_pos_s == LAST_X) & (y_pos_s == LAST_Y);
    end

    // Window shift register: advances on every beat, holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_r[r][c] <= {PIX_W{1'b0}};
                end
            end
        end else if (valid_in) begin
            win_r <= win_nxt_s;
        end
    end

    // Output registers: data and coordinates update only when a window emits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_out_r   <= {WIN_W{1'b0}};
            win_valid_r <= 1'b0;
            win_first_r <= 1'b0;
            win_last_r  <= 1'b0;
            win_col_r   <= {POS_W{1'b0}};
            win_row_r   <= {POS_W{1'b0}};
        end else begin
            win_valid_r <= emit_s;
            win_first_r <= first_s;
            win_last_r  <= last_s;
            if (emit_s) begin
                win_out_r <= win_flat_s;
                // Subtraction is safe: emit_s guarantees both positions >= K-1.
                win_col_r <= x_pos_s - K_M1;
                win_row_r <= y_pos_s - K_M1;
            end
        end
    end

    assign win_out   = win_out_r;
    assign win_valid = win_valid_r;
    assign win_first = win_first_r;
    assign win_last  = win_last_r;
    assign win_col   = win_col_r;
    assign win_row   = win_row_r;
    assign frame_err = frame_err_s;

endmodule

// File: tb/tb_window_5x5_gen.sv
// ---------------------------------------------------------------------------
// tb_window_5x5_gen
// Scoreboard bench: each beat issued pushes the expected window (computed
// directly from a frame image array and the raster position) into a queue;
// a monitor process pops and compares whenever win_valid is seen.
// ---------------------------------------------------------------------------
module tb_window_5x5_gen;

    localparam int W = 32;
    localparam int H = 32;

    typedef struct {
        logic [199:0] win;
        logic [4:0]   col;
        logic [4:0]   row;
        logic         first;
        logic         last;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         valid_in;
    logic         sof_in;
    logic [7:0]   pix_row0, pix_row1, pix_row2, pix_row3, pix_row4;
    logic [199:0] win_out;
    logic         win_valid, win_first, win_last;
    logic [4:0]   win_col, win_row;
    logic         frame_err;

    window_5x5_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .sof_in    (sof_in),
        .pix_row0  (pix_row0),
        .pix_row1  (pix_row1),
        .pix_row2  (pix_row2),
        .pix_row3  (pix_row3),
        .pix_row4  (pix_row4),
        .win_out   (win_out),
        .win_valid (win_valid),
        .win_first (win_first),
        .win_last  (win_last),
        .win_col   (win_col),
        .win_row   (win_row),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    exp_t         q[$];
    logic [7:0]   img [H][W];
    int           mx = 0;
    int           my = 0;
    logic         exp_err = 1'b0;
    int           win_cnt = 0;
    int           first_cnt = 0;
    logic [199:0] first_win = '0;

    task automatic chk(input bit ok, input string nm, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_at(input int x, input int y);
        if (y < 0) return 8'($urandom);
        return img[y][x];
    endfunction

    // Expected window: top-left image pixel (ex-4, ey-4), row-major layout.
    function automatic logic [199:0] model_win(input int ex, input int ey);
        logic [199:0] w;
        w = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[8*(5*r+c) +: 8] = img[ey-4+r][ex-4+c];
        return w;
    endfunction

    task automatic fill_img(input bit ramp);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = ramp ? 8'((x + y) & 255) : 8'($urandom);
    endtask

    task automatic beat(input bit sof);
        int   ex, ey;
        exp_t e;
        @(negedge clk);
        ex = sof ? 0 : mx;
        ey = sof ? 0 : my;
        if (sof && (mx != 0 || my != 0)) exp_err = 1'b1;
        rst_n    = 1'b1;
        valid_in = 1'b1;
        sof_in   = sof;
        pix_row0 = pix_at(ex, ey - 4);
        pix_row1 = pix_at(ex, ey - 3);
        pix_row2 = pix_at(ex, ey - 2);
        pix_row3 = pix_at(ex, ey - 1);
        pix_row4 = pix_at(ex, ey);
        if (ex >= 4 && ey >= 4) begin
            e.win   = model_win(ex, ey);
            e.col   = 5'(ex - 4);
            e.row   = 5'(ey - 4);
            e.first = (ex == 4 && ey == 4);
            e.last  = (ex == W - 1 && ey == H - 1);
            q.push_back(e);
        end
        if (ex == W - 1) begin
            mx = 0;
            my = (ey == H - 1) ? 0 : ey + 1;
        end else begin
            mx = ex + 1;
            my = ey;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        rst_n    = 1'b1;
        valid_in = 1'b0;
        sof_in   = 1'($urandom);
        pix_row0 = 8'($urandom);
        pix_row1 = 8'($urandom);
        pix_row2 = 8'($urandom);
        pix_row3 = 8'($urandom);
        pix_row4 = 8'($urandom);
    endtask

    // Reset dominates a simultaneous beat.
    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        valid_in = 1'b1;
        sof_in   = 1'b0;
        mx = 0;
        my = 0;
        exp_err = 1'b0;
    endtask

    task automatic stream_frame(input bit sof0, input bit idles);
        for (int i = 0; i < W * H; i++) begin
            beat(i == 0 ? sof0 : 1'b0);
            if (idles && ($urandom_range(0, 1) == 1)) idle();
        end
    endtask

    task automatic drain();
        repeat (3) idle();
        chk(q.size() == 0, "queue_drained", 200'(q.size()), 200'd0);
    endtask

    // Monitor: sample one time unit after each rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            chk(win_out === '0, "reset_win_out", win_out, 200'd0);
            chk({win_col, win_row, win_valid, win_first, win_last} === 14'd0,
                "reset_ctrl", 200'({win_col, win_row, win_valid, win_first, win_last}), 200'd0);
        end else begin
            if (!valid_in)
                chk(win_valid === 1'b0, "idle_no_valid", 200'(win_valid), 200'd0);
            if (win_valid === 1'b1) begin
                win_cnt++;
                if (win_first === 1'b1) begin
                    first_cnt++;
                    first_win = win_out;
                end
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_valid", 200'({win_col, win_row}), 200'd0);
                end else begin
                    e = q.pop_front();
                    chk(win_out === e.win, "win_out", win_out, e.win);
                    chk(win_col === e.col, "win_col", 200'(win_col), 200'(e.col));
                    chk(win_row === e.row, "win_row", 200'(win_row), 200'(e.row));
                    chk(win_first === e.first, "win_first", 200'(win_first), 200'(e.first));
                    chk(win_last === e.last, "win_last", 200'(win_last), 200'(e.last));
                end
            end
        end
        chk(frame_err === exp_err, "frame_err", 200'(frame_err), 200'(exp_err));
    end

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        pix_row0 = '0; pix_row1 = '0; pix_row2 = '0; pix_row3 = '0; pix_row4 = '0;
        repeat (2) @(negedge clk);

        // 1: ramp frame, back-to-back beats.
        fill_img(1'b1);
        win_cnt = 0; first_cnt = 0;
        stream_frame(1'b1, 1'b0);
        drain();
        chk(win_cnt == 784, "frame1_count", 200'(win_cnt), 200'd784);
        chk(first_win[7:0] == 8'h00, "first_pix00", 200'(first_win[7:0]), 200'h00);
        chk(first_win[8*24 +: 8] == 8'h08, "first_pix44", 200'(first_win[8*24 +: 8]), 200'h08);

        // 2: same ramp frame with random idle cycles between beats.
        win_cnt = 0;
        stream_frame(1'b0, 1'b1);
        drain();
        chk(win_cnt == 784, "idle_count", 200'(win_cnt), 200'd784);

        // 3: two random frames back-to-back.
        win_cnt = 0; first_cnt = 0;
        fill_img(1'b0);
        stream_frame(1'b1, 1'b0);
        fill_img(1'b0);
        stream_frame(1'b0, 1'b0);
        drain();
        chk(win_cnt == 1568, "b2b_count", 200'(win_cnt), 200'd1568);
        chk(first_cnt == 2, "b2b_firsts", 200'(first_cnt), 200'd2);

        // 4: misplaced sof at (10,3), then a full resynchronised frame.
        fill_img(1'b0);
        win_cnt = 0;
        beat(1'b1);
        while (!(mx == 10 && my == 3)) beat(1'b0);
        fill_img(1'b0);
        beat(1'b1);
        while (!(mx == 0 && my == 0)) beat(1'b0);
        drain();
        chk(win_cnt == 784, "resync_count", 200'(win_cnt), 200'd784);
        chk(frame_err === 1'b1, "err_sticky", 200'(frame_err), 200'd1);

        // 5: reset at (15,15), then a fresh frame without sof.
        fill_img(1'b0);
        beat(1'b0);
        while (!(mx == 15 && my == 15)) beat(1'b0);
        do_reset();
        idle();
        win_cnt = 0;
        fill_img(1'b0);
        stream_frame(1'b0, 1'b0);
        drain();
        chk(win_cnt == 784, "post_reset_count", 200'(win_cnt), 200'd784);
        chk(frame_err === 1'b0, "post_reset_err", 200'(frame_err), 200'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
